// File: rtl/arm_flags_pkg.sv
// Shared flag definitions for the processor status register and its users.
// Provides bit positions inside the packed {N,Z,C,V,M} status word and the
// common update masks used by ALU / shifter flag writers.
package arm_flags_pkg;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_M = 0;

  localparam logic [4:0] MASK_NZCV = 5'h1e;
  localparam logic [4:0] MASK_NZC  = 5'h1c;
  localparam logic [4:0] MASK_NZ   = 5'h18;
  localparam logic [4:0] MASK_V    = 5'h02;

endpackage

// File: rtl/flag_lifo.sv
// Saved-status LIFO: storage array plus occupancy counter.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset (count only)
//   push, pop     - already-qualified requests; caller never asserts both,
//                   never pushes when full and never pops when empty
//   din           - word to save on push
//   top           - word at the top of the stack (valid when !empty)
//   depth         - number of valid entries
//   full, empty   - occupancy flags
module flag_lifo #(
  parameter int WIDTH   = 5,
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   top,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  // Array index width; a single-entry stack still needs a 1-bit index.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_W-1:0] count;
  logic [DEPTH_W-1:0] top_ptr;

  assign top_ptr = count - 1'b1;
  assign top     = mem[top_ptr[IDX_W-1:0]];
  assign depth   = count;
  assign full    = (count == DEPTH_W'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (push) begin
      count <= count + 1'b1;
    end else if (pop) begin
      count <= count - 1'b1;
    end
  end

  // Storage is never cleared; only the count defines which entries are valid.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[count[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/spec_reg_stack.sv
// Processor status register with per-bit masked updates and a LIFO of saved
// status words for nested exception entry / return.
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   enable         - 0 freezes all state and forces flags_out to all ones
//   update_mask    - per-bit load enable for flag_in
//   flag_in        - new flag values {N,Z,C,V,M}
//   push / pop     - exception entry (save live word, set mode) / return
//   clear_err      - clears sticky error bits (a same-cycle new error wins)
//   flags_out      - live status word
//   depth, stack_empty, stack_full - LIFO occupancy
//   overflow_err, underflow_err    - sticky misuse indicators
module spec_reg_stack
  import arm_flags_pkg::*;
#(
  parameter int FLAG_W      = 5,
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [FLAG_W-1:0]  update_mask,
  input  logic [FLAG_W-1:0]  flag_in,
  input  logic               push,
  input  logic               pop,
  input  logic               clear_err,
  output logic [FLAG_W-1:0]  flags_out,
  output logic [DEPTH_W-1:0] depth,
  output logic               stack_empty,
  output logic               stack_full,
  output logic               overflow_err,
  output logic               underflow_err
);

  logic [FLAG_W-1:0] live;
  logic [FLAG_W-1:0] saved_top;
  logic              push_only;
  logic              pop_only;
  logic              do_push;
  logic              do_pop;
  logic              set_ovf;
  logic              set_unf;

  assign push_only = enable && push && !pop;
  assign pop_only  = enable && pop && !push;
  assign do_push   = push_only && !stack_full;
  assign do_pop    = pop_only && !stack_empty;
  assign set_ovf   = push_only && stack_full;
  assign set_unf   = pop_only && stack_empty;

  flag_lifo #(
    .WIDTH   (FLAG_W),
    .DEPTH   (STACK_DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_lifo (
    .clock (clock),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .din   (live),
    .top   (saved_top),
    .depth (depth),
    .full  (stack_full),
    .empty (stack_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      live          <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (enable) begin
      // Any stack request (including push&pop together) suppresses the mask update.
      if (do_push) begin
        live[FLAG_M] <= 1'b1;
      end else if (do_pop) begin
        live <= saved_top;
      end else if (!push && !pop) begin
        live <= (live & ~update_mask) | (flag_in & update_mask);
      end
      overflow_err  <= set_ovf || (overflow_err && !clear_err);
      underflow_err <= set_unf || (underflow_err && !clear_err);
    end
  end

  assign flags_out = enable ? live : {FLAG_W{1'b1}};

endmodule

// File: tb/tb_spec_reg_stack.sv
// Directed self-checking bench for spec_reg_stack (default parameters).
module tb_spec_reg_stack;
  import arm_flags_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [4:0] update_mask;
  logic [4:0] flag_in;
  logic       push;
  logic       pop;
  logic       clear_err;
  logic [4:0] flags_out;
  logic [2:0] depth;
  logic       stack_empty;
  logic       stack_full;
  logic       overflow_err;
  logic       underflow_err;

  int checks = 0;
  int errors = 0;

  spec_reg_stack dut (
    .clock         (clk),
    .reset         (reset),
    .enable        (enable),
    .update_mask   (update_mask),
    .flag_in       (flag_in),
    .push          (push),
    .pop           (pop),
    .clear_err     (clear_err),
    .flags_out     (flags_out),
    .depth         (depth),
    .stack_empty   (stack_empty),
    .stack_full    (stack_full),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic en, input logic [4:0] m,
                     input logic [4:0] f, input logic ps, input logic pp,
                     input logic clr);
    reset = rst; enable = en; update_mask = m; flag_in = f;
    push = ps; pop = pp; clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_state(input string tag, input logic [4:0] f, input logic [2:0] d,
                             input logic e, input logic fl, input logic o, input logic u);
    check({tag, ".flags"}, 32'(flags_out), 32'(f));
    check({tag, ".depth"}, 32'(depth), 32'(d));
    check({tag, ".empty"}, 32'(stack_empty), 32'(e));
    check({tag, ".full"}, 32'(stack_full), 32'(fl));
    check({tag, ".ovf"}, 32'(overflow_err), 32'(o));
    check({tag, ".unf"}, 32'(underflow_err), 32'(u));
  endtask

  initial begin
    // Reset
    cyc(1'b1, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0);
    check_state("reset", 5'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Masked updates
    cyc(1'b0, 1'b1, MASK_NZCV, 5'h16, 1'b0, 1'b0, 1'b0);
    check("upd_nzcv", 32'(flags_out), 32'h16);
    cyc(1'b0, 1'b1, MASK_V, 5'h00, 1'b0, 1'b0, 1'b0);
    check("upd_v", 32'(flags_out), 32'h14);

    // Freeze: nothing changes, outputs forced high
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 5'h1f, 5'h00, 1'b1, 1'b0, 1'b1);
      check("frozen.flags", 32'(flags_out), 32'h1f);
      check("frozen.depth", 32'(depth), 32'd0);
    end
    idle();
    check_state("unfreeze", 5'h14, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Push, masked update while nested, pop back
    cyc(1'b0, 1'b1, 5'h1f, 5'h00, 1'b1, 1'b0, 1'b0);
    check_state("push1", 5'h15, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, MASK_NZ, 5'h08, 1'b0, 1'b0, 1'b0);
    check("nested_upd", 32'(flags_out), 32'h0d);
    cyc(1'b0, 1'b1, 5'h1f, 5'h1f, 1'b0, 1'b1, 1'b0);
    check_state("pop1", 5'h14, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // push & pop together: no-op, mask ignored
    cyc(1'b0, 1'b1, 5'h1f, 5'h0b, 1'b1, 1'b1, 1'b0);
    check_state("pushpop", 5'h14, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Fill stack and overflow
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 5'h00, 5'h00, 1'b1, 1'b0, 1'b0);
    check_state("fill", 5'h15, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'h1f, 5'h00, 1'b1, 1'b0, 1'b0);
    check_state("overflow", 5'h15, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);

    // Drain (saved: 14,15,15,15) and underflow
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 5'h00, 5'h00, 1'b0, 1'b1, 1'b0);
      check("drain.flags", 32'(flags_out), 32'h15);
    end
    cyc(1'b0, 1'b1, 5'h00, 5'h00, 1'b0, 1'b1, 1'b0);
    check_state("drain_last", 5'h14, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 5'h1f, 5'h1f, 1'b0, 1'b1, 1'b0);
    check_state("underflow", 5'h14, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    // clear_err ignored while frozen
    cyc(1'b0, 1'b0, 5'h00, 5'h00, 1'b0, 1'b0, 1'b1);
    check_state("frozen_clr", 5'h1f, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    // clear_err
    cyc(1'b0, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0, 1'b1);
    check_state("clear", 5'h14, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // New error beats clear in the same cycle
    cyc(1'b0, 1'b1, 5'h00, 5'h00, 1'b0, 1'b1, 1'b1);
    check_state("set_wins", 5'h14, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Mode bit via mask bit 0
    cyc(1'b0, 1'b1, 5'h01, 5'h1f, 1'b0, 1'b0, 1'b1);
    check("mode_upd", 32'(flags_out), 32'h15);
    check("mode_upd.unf", 32'(underflow_err), 32'h0);

    // Reset cancels a simultaneous push
    cyc(1'b0, 1'b1, 5'h00, 5'h00, 1'b1, 1'b0, 1'b0);
    check("pre_rst.depth", 32'(depth), 32'd1);
    cyc(1'b1, 1'b1, 5'h00, 5'h00, 1'b1, 1'b0, 1'b0);
    check_state("rst_push", 5'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
